video_pixel_source: RTL and testbench
=====================================

// Module: video_pixel_source
// PURPOSE
// - Pixel supplier directly upstream of the HDMI timing driver.
// - Drains the SDRAM read-side FIFO (RGB565) in response to the driver's data_req.
// - Returns pixel_data one cycle later, when the driver samples it.
// - Re-aligns the FIFO and SDRAM read pointer every frame; substitutes fill colour on underflow.
// - Supports a built-in colour-bar test mode.
// PARAMETERS
// - H_DISP         1920     active pixels per line
// - V_DISP         1080     active lines per frame
// - FLUSH_CYCLES   16       cycles fifo_flush is held per frame
// - PREFILL_WORDS  256      FIFO level required before streaming starts
// - FIFO_CNT_W     10       width of fifo_rd_count
// - FILL_COLOR     16'h0000 RGB565 value sent on underflow / when not streaming
// PORTS
// - pixel_clk            in   1           pixel clock
// - sys_rst_n            in   1           reset, asynchronous, active-low
// - data_req             in   1           driver requests a pixel; data due next cycle
// - video_vs             in   1           driver vsync, active-low
// - pixel_xpos           in   12          driver x coordinate, valid in the cycle after data_req
// - test_pattern_en      in   1           1 = colour bars instead of FIFO data
// - fifo_rd_en           out  1           FIFO read strobe; fifo_rd_data valid one cycle later
// - fifo_rd_data         in   16          FIFO read data
// - fifo_empty           in   1           FIFO empty flag
// - fifo_rd_count        in   FIFO_CNT_W  FIFO fill level
// - fifo_flush           out  1           FIFO clear, held FLUSH_CYCLES cycles
// - frame_start          out  1           1-cycle pulse to SDRAM ctrl: rewind read address
// - pixel_data           out  16          RGB565 to driver
// - streaming            out  1           1 while in STREAM state
// - last_frame_underflow out  16          underflow count of the previous frame, saturating
// - frame_len_err        out  1           sticky: a frame did not read exactly H_DISP*V_DISP words
// BEHAVIOUR
// - Reset values:
//   - all outputs 0
//   - state IDLE
//   - counters 0
// - vs_fall is one cycle: video_vs registered once; vs_fall = prev 1 & current 0.
// - FSM:
//   - IDLE -> FLUSH on vs_fall.
//   - FLUSH: fifo_flush=1; frame_start=1 on the first FLUSH cycle only. After FLUSH_CYCLES -> PREFILL.
//   - PREFILL -> STREAM when fifo_rd_count >= PREFILL_WORDS.
//   - PREFILL: a vs_fall in this state restarts FLUSH (SDRAM too slow for a whole frame).
//   - STREAM -> FLUSH on vs_fall.
//   - vs_fall in any state -> FLUSH, restarting the flush counter.
// - Read path:
//   - fifo_rd_en = data_req & ~fifo_empty & (state==STREAM) & ~test_pattern_en. Combinational, no delay.
//   - rd_valid_d is fifo_rd_en registered.
//   - pixel_data is combinational from:
//     - test_pattern_en -> colour bar.
//     - else rd_valid_d -> fifo_rd_data.
//     - else FILL_COLOR.
// - Latency: data_req at cycle t -> pixel_data valid at t+1, matching the driver's registered DE.
// - Colour bars:
//   - 8 bars of H_DISP/8 px, indexed by pixel_xpos / (H_DISP/8), clamped to 7.
//   - Order: white, yellow, cyan, green, magenta, red, blue, black.
//   - Values: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
// - Underflow:
//   - Condition: data_req & (state==STREAM) & ~test_pattern_en & fifo_empty.
//   - Each one increments uf_cnt (16 b, saturates at FFFF).
//   - No FIFO read is issued on underflow; the pixel is not replayed.
// - Frame accounting:
//   - word_cnt (22 b) counts fifo_rd_en.
//   - On vs_fall: last_frame_underflow <= uf_cnt; uf_cnt <= 0.
//   - On vs_fall, if a STREAM frame completed and word_cnt != H_DISP*V_DISP: frame_len_err <= 1.
//   - Then word_cnt <= 0.
//   - frame_len_err clears only on reset.
// - Boundaries:
//   - vs_fall coincident with data_req: not possible in valid timing; if it occurs, vs_fall wins and no read is issued.
//   - test_pattern_en toggled mid-frame: takes effect next data_req; FIFO is not drained while set, so PREFILL/flush resync at next frame.
//   - fifo_empty rising between requests: handled per request.
//   - Reset mid-frame: everything returns to IDLE; no frame_start until the next vs_fall.
// STRUCTURE
// - Shared package (video_pkg): RGB565 colour constants, bar table, FSM state encoding (2 b), 1080p H_DISP/V_DISP defaults.
// - Sub-module video_colorbar_gen: combinational pixel_xpos -> RGB565 bar.
// - The rest stays flat: FSM, counters, read mux.
// TESTING
// - Reset, then vs_fall:
//   - frame_start pulses 1 cycle.
//   - fifo_flush high exactly 16 cycles.
//   - State PREFILL; streaming=0.
// - FIFO model:
//   - Fill to 256 -> streaming=1 next cycle.
//   - data_req pulse with fifo_rd_data=16'h1234 -> fifo_rd_en same cycle; pixel_data=1234 next cycle.
// - Empty FIFO in STREAM, 5 data_req:
//   - pixel_data=FILL_COLOR 5 times; fifo_rd_en never asserted.
//   - After next vs_fall, last_frame_underflow=5.
// - test_pattern_en=1:
//   - pixel_xpos=0 -> FFFF; 240 -> FFE0; 1919 -> 0000.
//   - fifo_rd_en stays 0.
// - Full 1920x1080 frame, then a second frame short by 1 word:
//   - frame_len_err=0 after the first vs_fall.
//   - frame_len_err=1 after the second, and stays set.
// - Other cases:
//   - Async reset asserted mid-STREAM: all outputs 0 immediately.
//   - Second vs_fall while in PREFILL: flush restarts.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the video pixel path: RGB565 colours, colour-bar table,
// pixel-source FSM encoding and 1080p display defaults.
package video_pkg;

  localparam int H_DISP_1080P = 1920;
  localparam int V_DISP_1080P = 1080;

  localparam int XPOS_W     = 12;
  localparam int RGB565_W   = 16;
  localparam int WORD_CNT_W = 22;
  localparam int UF_CNT_W   = 16;
  localparam int NUM_BARS   = 8;

  typedef logic [RGB565_W-1:0] rgb565_t;

  localparam rgb565_t RGB_WHITE   = 16'hFFFF;
  localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
  localparam rgb565_t RGB_CYAN    = 16'h07FF;
  localparam rgb565_t RGB_GREEN   = 16'h07E0;
  localparam rgb565_t RGB_MAGENTA = 16'hF81F;
  localparam rgb565_t RGB_RED     = 16'hF800;
  localparam rgb565_t RGB_BLUE    = 16'h001F;
  localparam rgb565_t RGB_BLACK   = 16'h0000;

  // Left-to-right order of the test-mode colour bars.
  localparam rgb565_t BAR_TABLE [NUM_BARS] = '{
    RGB_WHITE, RGB_YELLOW, RGB_CYAN, RGB_GREEN,
    RGB_MAGENTA, RGB_RED, RGB_BLUE, RGB_BLACK
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_PREFILL = 2'd2,
    ST_STREAM  = 2'd3
  } vsrc_state_e;

  function automatic rgb565_t bar_color(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/video_colorbar_gen.sv
// Combinational colour-bar generator: maps the driver x coordinate to one of
// eight equal-width RGB565 bars; coordinates past the last bar stay on it.
module video_colorbar_gen
  import video_pkg::*;
#(
  parameter int H_DISP = H_DISP_1080P
) (
  input  logic [XPOS_W-1:0] pixel_xpos,
  output rgb565_t           bar_rgb
);

  localparam logic [XPOS_W-1:0] BAR_W    = XPOS_W'(H_DISP / NUM_BARS);
  localparam logic [XPOS_W-1:0] LAST_BAR = XPOS_W'(NUM_BARS - 1);

  logic [XPOS_W-1:0] bar_idx_wide;
  logic [2:0]        bar_idx;

  always_comb begin
    bar_idx_wide = pixel_xpos / BAR_W;
    bar_idx      = (bar_idx_wide > LAST_BAR) ? 3'd7 : bar_idx_wide[2:0];
    bar_rgb      = bar_color(bar_idx);
  end

endmodule

// File: rtl/video_pixel_source.sv
// Pixel supplier for the HDMI timing driver: drains the SDRAM read FIFO on
// data_req, re-aligns FIFO and SDRAM pointer every frame, and tracks underflow.
module video_pixel_source
  import video_pkg::*;
#(
  parameter int            H_DISP        = H_DISP_1080P,
  parameter int            V_DISP        = V_DISP_1080P,
  parameter int            FLUSH_CYCLES  = 16,
  parameter int            PREFILL_WORDS = 256,
  parameter int            FIFO_CNT_W    = 10,
  parameter logic [15:0]   FILL_COLOR    = 16'h0000
) (
  input  logic                  pixel_clk,
  input  logic                  sys_rst_n,
  input  logic                  data_req,
  input  logic                  video_vs,
  input  logic [11:0]           pixel_xpos,
  input  logic                  test_pattern_en,
  output logic                  fifo_rd_en,
  input  logic [15:0]           fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [FIFO_CNT_W-1:0] fifo_rd_count,
  output logic                  fifo_flush,
  output logic                  frame_start,
  output logic [15:0]           pixel_data,
  output logic                  streaming,
  output logic [15:0]           last_frame_underflow,
  output logic                  frame_len_err
);

  localparam int                      FLUSH_CNT_W = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [FLUSH_CNT_W-1:0]  FLUSH_LAST  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FIFO_CNT_W-1:0]   PREFILL_LVL = FIFO_CNT_W'(PREFILL_WORDS);
  localparam logic [WORD_CNT_W-1:0]   FRAME_WORDS = WORD_CNT_W'(H_DISP * V_DISP);

  vsrc_state_e            state_q, state_d;
  logic                   vs_q, vs_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [UF_CNT_W-1:0]    uf_cnt_q, uf_cnt_d;
  logic [UF_CNT_W-1:0]    last_uf_q, last_uf_d;
  logic                   frame_len_err_q, frame_len_err_d;

  logic    vs_fall;
  logic    flush_done;
  logic    prefill_ok;
  logic    rd_grant;
  logic    underflow;
  rgb565_t bar_rgb;

  video_colorbar_gen #(
    .H_DISP (H_DISP)
  ) u_colorbar (
    .pixel_xpos (pixel_xpos),
    .bar_rgb    (bar_rgb)
  );

  // vsync falling edge is seen in the same cycle video_vs drops.
  always_comb begin
    vs_d       = video_vs;
    vs_fall    = vs_q & ~video_vs;
    flush_done = (flush_cnt_q == FLUSH_LAST);
    prefill_ok = (fifo_rd_count >= PREFILL_LVL);
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (vs_fall) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_FLUSH:   if (flush_done) state_d = ST_PREFILL;
        ST_PREFILL: if (prefill_ok) state_d = ST_STREAM;
        ST_STREAM:  state_d = ST_STREAM;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_flush  = (state_q == ST_FLUSH);
    frame_start = (state_q == ST_FLUSH) && (flush_cnt_q == '0);
    streaming   = (state_q == ST_STREAM);
  end

  // A vsync fall restarts the flush window from its first cycle.
  always_comb begin
    flush_cnt_d = '0;
    if (!vs_fall && state_q == ST_FLUSH && !flush_done) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // A request coincident with a vsync fall is dropped: the frame restarts.
  always_comb begin
    rd_grant   = data_req & (state_q == ST_STREAM) & ~test_pattern_en & ~vs_fall;
    fifo_rd_en = rd_grant & ~fifo_empty;
    underflow  = rd_grant & fifo_empty;
    rd_valid_d = fifo_rd_en;
  end

  always_comb begin
    if (test_pattern_en) begin
      pixel_data = bar_rgb;
    end else if (rd_valid_q) begin
      pixel_data = fifo_rd_data;
    end else begin
      pixel_data = FILL_COLOR;
    end
  end

  always_comb begin
    word_cnt_d      = word_cnt_q;
    uf_cnt_d        = uf_cnt_q;
    last_uf_d       = last_uf_q;
    frame_len_err_d = frame_len_err_q;
    if (vs_fall) begin
      last_uf_d  = uf_cnt_q;
      uf_cnt_d   = '0;
      word_cnt_d = '0;
      if (state_q == ST_STREAM && word_cnt_q != FRAME_WORDS) begin
        frame_len_err_d = 1'b1;
      end
    end else begin
      if (fifo_rd_en) begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
      if (underflow && uf_cnt_q != '1) begin
        uf_cnt_d = uf_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q            <= 1'b0;
      flush_cnt_q     <= '0;
      rd_valid_q      <= 1'b0;
      word_cnt_q      <= '0;
      uf_cnt_q        <= '0;
      last_uf_q       <= '0;
      frame_len_err_q <= 1'b0;
    end else begin
      vs_q            <= vs_d;
      flush_cnt_q     <= flush_cnt_d;
      rd_valid_q      <= rd_valid_d;
      word_cnt_q      <= word_cnt_d;
      uf_cnt_q        <= uf_cnt_d;
      last_uf_q       <= last_uf_d;
      frame_len_err_q <= frame_len_err_d;
    end
  end

  always_comb begin
    last_frame_underflow = last_uf_q;
    frame_len_err        = frame_len_err_q;
  end

endmodule

// File: tb/tb_video_pixel_source.sv
// Bench for video_pixel_source: directed frame scenarios plus randomized traffic,
// all checked every cycle against a behavioural frame/stream model.
module tb_video_pixel_source;

  localparam int H     = 1920;
  localparam int V     = 2;
  localparam int FRAME = H * V;
  localparam int FLUSH = 16;
  localparam int PRE   = 256;
  localparam logic [15:0] FILL = 16'h0000;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        data_req = 1'b0;
  logic        video_vs = 1'b1;
  logic [11:0] pixel_xpos = '0;
  logic        test_pattern_en = 1'b0;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic [9:0]  fifo_rd_count = '0;
  logic        fifo_flush;
  logic        frame_start;
  logic [15:0] pixel_data;
  logic        streaming;
  logic [15:0] last_frame_underflow;
  logic        frame_len_err;

  video_pixel_source #(.H_DISP(H), .V_DISP(V)) dut (
    .pixel_clk            (pixel_clk),
    .sys_rst_n            (sys_rst_n),
    .data_req             (data_req),
    .video_vs             (video_vs),
    .pixel_xpos           (pixel_xpos),
    .test_pattern_en      (test_pattern_en),
    .fifo_rd_en           (fifo_rd_en),
    .fifo_rd_data         (fifo_rd_data),
    .fifo_empty           (fifo_empty),
    .fifo_rd_count        (fifo_rd_count),
    .fifo_flush           (fifo_flush),
    .frame_start          (frame_start),
    .pixel_data           (pixel_data),
    .streaming            (streaming),
    .last_frame_underflow (last_frame_underflow),
    .frame_len_err        (frame_len_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus for the next cycle
  logic        s_rst = 1'b0, s_vs = 1'b1, s_req = 1'b0, s_tp = 1'b0;
  logic [11:0] s_xpos = '0;
  int          s_cnt = 0;

  // bench-side FIFO contents and the word it presents after a read
  logic [15:0] fifo_q [$];
  logic [15:0] next_rdata = '0;

  // behavioural model: frame phase as countdown/flags, plus frame statistics
  bit          m_idle, m_stream, m_vs_prev, m_err, m_pend_valid;
  int          m_flush_left, m_words, m_uf, m_last_uf;
  logic [15:0] m_pend_val;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bar_ref(input logic [11:0] x);
    int i;
    i = int'(x) / (H / 8);
    if (i > 7) i = 7;
    return BARS[i];
  endfunction

  task automatic model_reset();
    m_idle = 1; m_stream = 0; m_vs_prev = 0; m_err = 0; m_pend_valid = 0;
    m_flush_left = 0; m_words = 0; m_uf = 0; m_last_uf = 0; m_pend_val = '0;
  endtask

  task automatic tick();
    logic vfall, e_rd;
    logic [15:0] e_pix;
    @(posedge pixel_clk);
    #1;
    sys_rst_n       = s_rst;
    video_vs        = s_vs;
    data_req        = s_req;
    test_pattern_en = s_tp;
    pixel_xpos      = s_xpos;
    fifo_rd_count   = 10'(s_cnt);
    fifo_rd_data    = next_rdata;
    fifo_empty      = (fifo_q.size() == 0);
    #4;
    if (!sys_rst_n) model_reset();
    vfall = m_vs_prev && !video_vs;
    e_rd  = data_req && !fifo_empty && m_stream && !test_pattern_en && !vfall;
    e_pix = test_pattern_en ? bar_ref(pixel_xpos) : (m_pend_valid ? m_pend_val : FILL);
    chk_eq("fifo_rd_en", fifo_rd_en, e_rd);
    chk_eq("fifo_flush", fifo_flush, m_flush_left > 0);
    chk_eq("frame_start", frame_start, m_flush_left == FLUSH);
    chk_eq("streaming", streaming, m_stream);
    chk_eq("pixel_data", pixel_data, e_pix);
    chk_eq("last_uf", last_frame_underflow, 32'(m_last_uf));
    chk_eq("frame_len_err", frame_len_err, m_err);
    if (sys_rst_n) begin
      if (vfall) begin
        m_last_uf = m_uf;
        if (m_stream && m_words != FRAME) m_err = 1;
        m_words = 0; m_uf = 0;
        m_flush_left = FLUSH; m_idle = 0; m_stream = 0;
      end else begin
        if (e_rd) m_words++;
        if (data_req && m_stream && !test_pattern_en && fifo_empty && m_uf < 65535) m_uf++;
        if (m_flush_left > 0) m_flush_left--;
        else if (!m_idle && !m_stream && int'(fifo_rd_count) >= PRE) m_stream = 1;
      end
      m_pend_valid = e_rd;
      if (e_rd) m_pend_val = fifo_q[0];
      m_vs_prev = video_vs;
    end
    if (fifo_rd_en && fifo_q.size() > 0) next_rdata = fifo_q.pop_front();
    else next_rdata = 16'($urandom);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    s_rst = 1'b0; s_req = 1'b0; s_tp = 1'b0; s_vs = 1'b1; s_cnt = 0;
    fifo_q.delete();
    repeat (3) tick();
    s_rst = 1'b1;
    tick();
  endtask

  task automatic vs_pulse();
    s_vs = 1'b0;
    tick();
    s_vs = 1'b1;
    tick();
  endtask

  task automatic to_stream();
    vs_pulse();
    s_cnt = 0;
    repeat (18) tick();
    s_cnt = PRE;
    tick();
    s_cnt = 0;
    tick();
  endtask

  task automatic stream_words(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(16'($urandom));
    s_req = 1'b1;
    repeat (n) tick();
    s_req = 1'b0;
    tick();
  endtask

  initial begin
    int n_fl, n_fs, n_rd, low_left;
    model_reset();

    // reset state
    do_reset();
    s_rst = 1'b0;
    tick();
    chk_eq("rst_flush", fifo_flush, 0);
    chk_eq("rst_stream", streaming, 0);
    chk_eq("rst_pixel", pixel_data, 0);
    s_rst = 1'b1;
    tick();

    // first vsync fall: one frame_start, exactly FLUSH cycles of flush
    tick();
    s_vs = 1'b0;
    tick();
    s_vs = 1'b1;
    n_fl = 0; n_fs = 0;
    repeat (20) begin
      tick();
      n_fl += int'(fifo_flush);
      n_fs += int'(frame_start);
    end
    chk_eq("flush_len", n_fl, FLUSH);
    chk_eq("fs_pulses", n_fs, 1);
    chk_eq("prefill_not_streaming", streaming, 0);

    // prefill threshold
    s_cnt = PRE - 1;
    tick();
    tick();
    chk_eq("below_prefill", streaming, 0);
    s_cnt = PRE;
    tick();
    s_cnt = 0;
    tick();
    chk_eq("prefill_reached", streaming, 1);

    // single read
    fifo_q.push_back(16'h1234);
    s_req = 1'b1;
    tick();
    chk_eq("rd_en_same_cycle", fifo_rd_en, 1);
    s_req = 1'b0;
    tick();
    chk_eq("pix_1234", pixel_data, 16'h1234);

    // underflow on an empty FIFO
    n_rd = 0;
    repeat (5) begin
      s_req = 1'b1;
      tick();
      n_rd += int'(fifo_rd_en);
      s_req = 1'b0;
      tick();
      chk_eq("uf_pixel_fill", pixel_data, FILL);
    end
    chk_eq("uf_no_reads", n_rd, 0);
    vs_pulse();
    chk_eq("last_uf_5", last_frame_underflow, 5);

    // colour bars in STREAM never read the FIFO
    do_reset();
    to_stream();
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'($urandom));
    s_tp = 1'b1; s_req = 1'b1;
    s_xpos = 12'd0;    tick(); chk_eq("bar_x0", pixel_data, 16'hFFFF); chk_eq("bar_rd0", fifo_rd_en, 0);
    s_xpos = 12'd240;  tick(); chk_eq("bar_x240", pixel_data, 16'hFFE0); chk_eq("bar_rd240", fifo_rd_en, 0);
    s_xpos = 12'd1919; tick(); chk_eq("bar_x1919", pixel_data, 16'h0000); chk_eq("bar_rd1919", fifo_rd_en, 0);
    s_xpos = 12'd1000; tick(); chk_eq("bar_x1000", pixel_data, 16'hF81F);
    s_tp = 1'b0; s_req = 1'b0;
    tick();

    // full frame, then a frame short by one word, then a full one again
    do_reset();
    to_stream();
    stream_words(FRAME);
    vs_pulse();
    chk_eq("len_full_ok", frame_len_err, 0);
    repeat (18) tick();
    s_cnt = PRE; tick(); s_cnt = 0; tick();
    stream_words(FRAME - 1);
    vs_pulse();
    chk_eq("len_short_err", frame_len_err, 1);
    repeat (18) tick();
    s_cnt = PRE; tick(); s_cnt = 0; tick();
    stream_words(FRAME);
    vs_pulse();
    chk_eq("len_err_sticky", frame_len_err, 1);

    // second vsync fall while waiting in PREFILL restarts the flush
    do_reset();
    vs_pulse();
    repeat (18) tick();
    s_vs = 1'b0;
    tick();
    s_vs = 1'b1;
    n_fl = 0; n_fs = 0;
    repeat (20) begin
      tick();
      n_fl += int'(fifo_flush);
      n_fs += int'(frame_start);
    end
    chk_eq("reflush_len", n_fl, FLUSH);
    chk_eq("reflush_fs", n_fs, 1);

    // asynchronous reset mid-STREAM clears outputs without a clock edge
    do_reset();
    to_stream();
    for (int i = 0; i < 4; i++) fifo_q.push_back(16'($urandom));
    s_req = 1'b1;
    tick();
    tick();
    #1;
    sys_rst_n = 1'b0;
    s_rst = 1'b0;
    #1;
    chk_eq("arst_rd_en", fifo_rd_en, 0);
    chk_eq("arst_stream", streaming, 0);
    chk_eq("arst_pixel", pixel_data, 0);
    chk_eq("arst_flush", fifo_flush, 0);
    chk_eq("arst_fs", frame_start, 0);
    s_req = 1'b0;
    tick();
    s_rst = 1'b1;
    tick();

    // randomized traffic
    low_left = 0;
    for (int c = 0; c < 20000; c++) begin
      if (low_left > 0) begin
        s_vs = 1'b0;
        low_left--;
      end else begin
        s_vs = 1'b1;
        if ($urandom_range(0, 700) == 0) low_left = int'($urandom_range(1, 3));
      end
      s_req  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 400) == 0) s_tp = ~s_tp;
      s_xpos = 12'($urandom);
      s_cnt  = int'($urandom_range(0, 400));
      s_rst  = ($urandom_range(0, 5000) != 0);
      if ($urandom_range(0, 3) != 0 && fifo_q.size() < 600) fifo_q.push_back(16'($urandom));
      tick();
    end
    s_rst = 1'b1;
    s_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
